// File: rtl/decode_if.sv
// decode_if: IF/ID inputs, writeback port and ID/EX outputs of decode_stage_p.
interface decode_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [31:0] instr;
    logic if_id_valid, flush, wb_regwrite;
    logic [AW-1:0] wb_write_reg;
    logic [DW-1:0] wb_write_data;
    logic pc_write, if_id_write, jmp, branch_taken, ex_valid;
    logic [DW-1:0] ex_rs_content, ex_rt_content, ex_imm;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [2:0] ex_aluop;
    logic ex_alusrc, ex_dst, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
    modport master (
        output instr, if_id_valid, flush, wb_regwrite, wb_write_reg, wb_write_data,
        input pc_write, if_id_write, jmp, branch_taken, ex_valid, ex_rs_content, ex_rt_content,
        ex_imm, ex_rs, ex_rt, ex_rd, ex_aluop, ex_alusrc, ex_dst, ex_memread, ex_memwrite,
        ex_memtoreg, ex_regwrite
    );
    modport slave (
        input instr, if_id_valid, flush, wb_regwrite, wb_write_reg, wb_write_data,
        output pc_write, if_id_write, jmp, branch_taken, ex_valid, ex_rs_content, ex_rt_content,
        ex_imm, ex_rs, ex_rt, ex_rd, ex_aluop, ex_alusrc, ex_dst, ex_memread, ex_memwrite,
        ex_memtoreg, ex_regwrite
    );
endinterface

// File: rtl/decode_stage_p.sv
// decode_stage_p: ID stage with register file, hazard detection, stall FSM and ID/EX register.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data into register reads.
module decode_stage_p #(
    parameter int DW = 32,
    parameter int NREG = 32,
    parameter int LOAD_LAT = 1
) (
    input logic clk,
    input logic rst,
    decode_if.slave bus
);
    localparam int AW = $clog2(NREG);
    typedef enum logic {IDLE, STALL} state_t;
    state_t state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [DW-1:0] rf [NREG];
    logic [5:0] op, fn;
    logic [AW-1:0] rs, rt, ex_dest;
    logic is_r, is_lw, is_sw, is_addi, is_beq, is_bne, is_j, is_br, r_ok, legal;
    logic [2:0] r_aluop, aluop;
    logic byp_s, byp_t;
    logic [DW-1:0] rs_val, rt_val;
    logic lu_hz, br_hz, stall, go, ld;

    assign op = bus.instr[31:26];
    assign fn = bus.instr[5:0];
    assign rs = bus.instr[21 +: AW];
    assign rt = bus.instr[16 +: AW];
    assign is_r = op == 6'h00;
    assign is_lw = op == 6'h23;
    assign is_sw = op == 6'h2B;
    assign is_addi = op == 6'h08;
    assign is_beq = op == 6'h04;
    assign is_bne = op == 6'h05;
    assign is_j = op == 6'h02;
    assign is_br = is_beq | is_bne;
    assign r_ok = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    assign legal = (is_r & r_ok) | is_lw | is_sw | is_addi | is_br | is_j;
    assign r_aluop = fn == 6'h20 ? 3'b010 : fn == 6'h22 ? 3'b110 : fn == 6'h24 ? 3'b000 :
                     fn == 6'h25 ? 3'b001 : 3'b111;
    assign aluop = is_r ? r_aluop : is_br ? 3'b110 : (is_lw | is_sw | is_addi) ? 3'b010 : 3'b000;

`ifdef DECODE_WB_BYPASS_EN
    assign byp_s = bus.wb_regwrite && bus.wb_write_reg != '0 && bus.wb_write_reg == rs;
    assign byp_t = bus.wb_regwrite && bus.wb_write_reg != '0 && bus.wb_write_reg == rt;
`else
    assign byp_s = 1'b0;
    assign byp_t = 1'b0;
`endif
    assign rs_val = rs == '0 ? '0 : byp_s ? bus.wb_write_data : rf[rs];
    assign rt_val = rt == '0 ? '0 : byp_t ? bus.wb_write_data : rf[rt];

    // rt is only a source operand for R-type, sw and branches
    assign lu_hz = bus.ex_valid && bus.ex_memread && bus.ex_rt != '0 &&
                   (bus.ex_rt == rs || ((is_r | is_sw | is_br) && bus.ex_rt == rt));
    assign ex_dest = bus.ex_dst ? bus.ex_rd : bus.ex_rt;
    assign br_hz = is_br && bus.ex_valid && bus.ex_regwrite && ex_dest != '0 &&
                   (ex_dest == rs || ex_dest == rt);
    assign stall = lu_hz | br_hz | (state == STALL);
    assign go = bus.if_id_valid & ~stall & ~bus.flush;
    assign ld = go & legal;
    assign bus.pc_write = ~stall;
    assign bus.if_id_write = ~stall;
    assign bus.jmp = go & is_j;
    assign bus.branch_taken = go & ((is_beq & (rs_val == rt_val)) | (is_bne & (rs_val != rt_val)));

    // the hazard cycle itself is the first stall cycle, STALL covers the remaining LOAD_LAT-1
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        if (bus.flush) begin
            state_n = IDLE;
            cnt_n = '0;
        end else if (state == STALL) begin
            cnt_n = cnt - 2'd1;
            state_n = cnt == 2'd1 ? IDLE : STALL;
        end else if (lu_hz && LOAD_LAT > 1) begin
            state_n = STALL;
            cnt_n = 2'(LOAD_LAT - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            bus.ex_valid <= 1'b0;
            bus.ex_aluop <= '0;
            bus.ex_alusrc <= 1'b0;
            bus.ex_dst <= 1'b0;
            bus.ex_memread <= 1'b0;
            bus.ex_memwrite <= 1'b0;
            bus.ex_memtoreg <= 1'b0;
            bus.ex_regwrite <= 1'b0;
            bus.ex_rs_content <= '0;
            bus.ex_rt_content <= '0;
            bus.ex_imm <= '0;
            bus.ex_rs <= '0;
            bus.ex_rt <= '0;
            bus.ex_rd <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (bus.wb_regwrite && bus.wb_write_reg != '0) rf[bus.wb_write_reg] <= bus.wb_write_data;
            bus.ex_valid <= ld;
            bus.ex_aluop <= ld ? aluop : 3'b000;
            bus.ex_alusrc <= ld & (is_lw | is_sw | is_addi);
            bus.ex_dst <= ld & is_r;
            bus.ex_memread <= ld & is_lw;
            bus.ex_memwrite <= ld & is_sw;
            bus.ex_memtoreg <= ld & is_lw;
            bus.ex_regwrite <= ld & (is_r | is_lw | is_addi);
            bus.ex_rs_content <= rs_val;
            bus.ex_rt_content <= rt_val;
            bus.ex_imm <= DW'($signed(bus.instr[15:0]));
            bus.ex_rs <= rs;
            bus.ex_rt <= rt;
            bus.ex_rd <= bus.instr[11 +: AW];
        end
    end
endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed scenarios plus random instruction stream against a cycle model.
module tb_decode_stage_p;
    localparam int DW = 32, NREG = 32, AW = 5, LL = 2;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    decode_if #(.DW(DW), .AW(AW)) bus();
    decode_stage_p #(.DW(DW), .NREG(NREG), .LOAD_LAT(LL)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, failures = 0;
    logic [DW-1:0] mreg [NREG];
    logic [9:0] m_ctl;
    logic [DW-1:0] m_rsc, m_rtc, m_imm;
    logic [AW-1:0] m_rs, m_rt, m_rd;
    int stall_left;
    logic last_pcw, last_exv, last_bt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int s, input int t, input int d, input logic [5:0] f);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] o, input int s, input int t, input logic [15:0] imm);
        return {o, 5'(s), 5'(t), imm};
    endfunction

    // {valid, aluop, alusrc, dst, memread, memwrite, memtoreg, regwrite}
    function automatic logic [9:0] dec(input logic [31:0] ins);
        logic [9:0] c;
        c = '0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: c = {1'b1, 3'b010, 6'b010001};
                6'h22: c = {1'b1, 3'b110, 6'b010001};
                6'h24: c = {1'b1, 3'b000, 6'b010001};
                6'h25: c = {1'b1, 3'b001, 6'b010001};
                6'h2A: c = {1'b1, 3'b111, 6'b010001};
                default: c = '0;
            endcase
            6'h23: c = {1'b1, 3'b010, 6'b101011};
            6'h2B: c = {1'b1, 3'b010, 6'b100100};
            6'h08: c = {1'b1, 3'b010, 6'b100001};
            6'h04, 6'h05: c = {1'b1, 3'b110, 6'b000000};
            6'h02: c = {1'b1, 3'b000, 6'b000000};
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [DW-1:0] rdm(input logic [AW-1:0] r, input logic we, input logic [AW-1:0] wr,
                                          input logic [DW-1:0] wd);
`ifdef DECODE_WB_BYPASS_EN
        if (we && r != 0 && wr == r) return wd;
`endif
        return r == 0 ? '0 : mreg[r];
    endfunction

    task automatic cyc(input logic [31:0] ins, input logic v, input logic fl, input logic we,
                       input logic [AW-1:0] wr, input logic [DW-1:0] wd);
        logic [5:0] op;
        logic [AW-1:0] rs, rt, dst;
        logic [DW-1:0] a, b;
        logic lu, br, st, go;
        @(negedge clk);
        bus.instr = ins;
        bus.if_id_valid = v;
        bus.flush = fl;
        bus.wb_regwrite = we;
        bus.wb_write_reg = wr;
        bus.wb_write_data = wd;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        a = rdm(rs, we, wr, wd);
        b = rdm(rt, we, wr, wd);
        dst = m_ctl[4] ? m_rd : m_rt;
        lu = m_ctl[9] && m_ctl[3] && m_rt != 0 &&
             (m_rt == rs || (op inside {6'h00, 6'h2B, 6'h04, 6'h05} && m_rt == rt));
        br = op inside {6'h04, 6'h05} && m_ctl[9] && m_ctl[0] && dst != 0 && (dst == rs || dst == rt);
        st = lu || br || stall_left > 0;
        go = v && !st && !fl;
        #1;
        check("pc_write", bus.pc_write, !st);
        check("if_id_write", bus.if_id_write, !st);
        check("branch_taken", bus.branch_taken, go && ((op == 6'h04 && a == b) || (op == 6'h05 && a != b)));
        check("jmp", bus.jmp, go && op == 6'h02);
        last_pcw = bus.pc_write;
        last_bt = bus.branch_taken;
        stall_left = fl ? 0 : stall_left > 0 ? stall_left - 1 : lu ? LL - 1 : 0;
        m_ctl = go ? dec(ins) : '0;
        m_rsc = a;
        m_rtc = b;
        m_rs = rs;
        m_rt = rt;
        m_rd = ins[15:11];
        m_imm = {{16{ins[15]}}, ins[15:0]};
        if (we && wr != 0) mreg[wr] = wd;
        @(posedge clk);
        #1;
        check("ex_ctl", {bus.ex_valid, bus.ex_aluop, bus.ex_alusrc, bus.ex_dst, bus.ex_memread,
                         bus.ex_memwrite, bus.ex_memtoreg, bus.ex_regwrite}, m_ctl);
        if (m_ctl[9]) begin
            check("ex_ops", {bus.ex_rs_content, bus.ex_rt_content}, {m_rsc, m_rtc});
            check("ex_imm", bus.ex_imm, m_imm);
            check("ex_regs", {bus.ex_rs, bus.ex_rt, bus.ex_rd}, {m_rs, m_rt, m_rd});
        end
        last_exv = bus.ex_valid;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.instr = '0;
        bus.if_id_valid = 1'b0;
        bus.flush = 1'b0;
        bus.wb_regwrite = 1'b0;
        bus.wb_write_reg = '0;
        bus.wb_write_data = '0;
        @(posedge clk);
        #1;
        check("rst_ctl", {bus.ex_valid, bus.ex_aluop, bus.ex_alusrc, bus.ex_dst, bus.ex_memread,
                          bus.ex_memwrite, bus.ex_memtoreg, bus.ex_regwrite}, 0);
        check("rst_data", {bus.ex_rs_content, bus.ex_rt_content}, 0);
        check("rst_fields", {bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_rd}, 0);
        for (int i = 0; i < NREG; i++) mreg[i] = '0;
        m_ctl = '0;
        m_rsc = '0;
        m_rtc = '0;
        m_imm = '0;
        m_rs = '0;
        m_rt = '0;
        m_rd = '0;
        stall_left = 0;
        rst = 1'b1;
    endtask

    initial begin
        logic p0, p1, p2, e0, e1, e2;
        logic [5:0] op, fn;
        logic [4:0] rdf;
        int k;
        bus.instr = '0;
        bus.if_id_valid = 1'b0;
        bus.flush = 1'b0;
        bus.wb_regwrite = 1'b0;
        bus.wb_write_reg = '0;
        bus.wb_write_data = '0;
        do_reset();
        cyc(0, 0, 0, 1, 5, 32'h1234);
        check("post_rst_pc_write", last_pcw, 1);
        cyc(r_ins(5, 5, 3, 6'h20), 1, 0, 0, 0, 0);
        check("add_rs_content", bus.ex_rs_content, 32'h1234);
        check("add_ctl", {bus.ex_aluop, bus.ex_regwrite, bus.ex_dst}, {3'b010, 1'b1, 1'b1});

        cyc(i_ins(6'h23, 1, 2, 16'h0), 1, 0, 0, 0, 0);
        cyc(r_ins(2, 1, 4, 6'h20), 1, 0, 0, 0, 0); p0 = last_pcw; e0 = last_exv;
        cyc(r_ins(2, 1, 4, 6'h20), 1, 0, 0, 0, 0); p1 = last_pcw; e1 = last_exv;
        cyc(r_ins(2, 1, 4, 6'h20), 1, 0, 0, 0, 0); p2 = last_pcw; e2 = last_exv;
        check("loaduse_pc_write", {p0, p1, p2}, 3'b001);
        check("loaduse_ex_valid", {e0, e1, e2}, 3'b001);

        cyc(0, 0, 0, 1, 1, 7);
        cyc(0, 0, 0, 1, 2, 7);
        cyc(i_ins(6'h04, 1, 2, 16'h10), 1, 0, 0, 0, 0);
        check("beq_equal", last_bt, 1);
        cyc(i_ins(6'h05, 1, 2, 16'h10), 1, 0, 0, 0, 0);
        check("bne_equal", last_bt, 0);
        cyc(0, 0, 0, 1, 2, 8);
        cyc(i_ins(6'h04, 1, 2, 16'h10), 1, 0, 0, 0, 0);
        check("beq_differ", last_bt, 0);
        cyc(i_ins(6'h05, 1, 2, 16'h10), 1, 0, 0, 0, 0);
        check("bne_differ", last_bt, 1);

        cyc(0, 0, 0, 1, 6, 32'h1111);
        cyc(r_ins(6, 0, 7, 6'h20), 1, 0, 1, 6, 32'hABCD);
`ifdef DECODE_WB_BYPASS_EN
        check("wb_same_cycle", bus.ex_rs_content, 32'hABCD);
`else
        check("wb_same_cycle", bus.ex_rs_content, 32'h1111);
`endif

        cyc(i_ins(6'h23, 1, 2, 16'h4), 1, 0, 0, 0, 0);
        cyc(r_ins(2, 1, 4, 6'h20), 1, 0, 0, 0, 0);
        cyc(r_ins(2, 1, 4, 6'h20), 1, 1, 0, 0, 0);
        check("flush_ex_valid", last_exv, 0);
        cyc(r_ins(2, 1, 4, 6'h20), 1, 0, 0, 0, 0);
        check("flush_pc_write", last_pcw, 1);
        check("flush_issue", last_exv, 1);
        cyc(0, 0, 0, 1, 0, 32'hFFFF);
        cyc(r_ins(0, 0, 8, 6'h20), 1, 0, 0, 0, 0);
        check("r0_reads_zero", bus.ex_rs_content, 0);

        cyc(i_ins(6'h23, 1, 2, 16'h0), 1, 0, 0, 0, 0);
        cyc(r_ins(2, 1, 4, 6'h20), 1, 0, 0, 0, 0);
        do_reset();
        cyc(r_ins(2, 1, 4, 6'h20), 1, 0, 0, 0, 0);
        check("rst_abort_stall", last_pcw, 1);

        for (int n = 0; n < 600; n++) begin
            k = $urandom_range(0, 8);
            op = k <= 1 ? 6'h00 : k == 2 ? 6'h23 : k == 3 ? 6'h2B : k == 4 ? 6'h08 :
                 k == 5 ? 6'h04 : k == 6 ? 6'h05 : k == 7 ? 6'h02 : 6'($urandom);
            k = $urandom_range(0, 5);
            fn = k == 0 ? 6'h20 : k == 1 ? 6'h22 : k == 2 ? 6'h24 : k == 3 ? 6'h25 : k == 4 ? 6'h2A : 6'($urandom);
            rdf = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 7));
            cyc({op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rdf, 5'($urandom), fn},
                $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, 1'($urandom),
                5'($urandom_range(0, 7)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
